// File: rtl/usb_dma_controller.sv
// USB debug DMA sequencer: drains the USB RX FIFO into cartridge SDRAM, one 32-bit word per
// bus write, at a programmed bank/word address for a programmed number of words.
module usb_dma_controller #(
  parameter int unsigned LENGTH_W = 20,
  parameter int unsigned ADDR_W   = 24
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_dma_start,
  input  logic                i_dma_flush,
  input  logic [3:0]          i_dma_bank,
  input  logic [ADDR_W-1:0]   i_dma_address,
  input  logic [LENGTH_W-1:0] i_dma_length,
  output logic                o_dma_busy,
  output logic                o_dma_done,
  input  logic                i_fifo_empty,
  output logic                o_fifo_read,
  input  logic [31:0]         i_fifo_data,
  output logic                o_mem_request,
  output logic                o_mem_write,
  output logic [3:0]          o_mem_bank,
  output logic [ADDR_W-1:0]   o_mem_address,
  output logic [31:0]         o_mem_data,
  input  logic                i_mem_ack
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StLatch = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic                abort_q, abort_d;
  logic [LENGTH_W-1:0] remaining_q, remaining_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fifo_read_q, fifo_read_d;
  logic                mem_request_q, mem_request_d;
  logic [3:0]          bank_q, bank_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [31:0]         data_q, data_d;

  always_comb begin
    state_d       = state_q;
    abort_d       = abort_q;
    remaining_d   = remaining_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    fifo_read_d   = 1'b0;
    mem_request_d = mem_request_q;
    bank_d        = bank_q;
    address_d     = address_q;
    data_d        = data_q;

    case (state_q)
      StIdle: begin
        // Start has priority over a simultaneous flush; flush alone is a no-op here.
        if (i_dma_start) begin
          bank_d      = i_dma_bank;
          address_d   = i_dma_address;
          remaining_d = i_dma_length;
          busy_d      = 1'b1;
          state_d     = (i_dma_length == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        // An abort seen here ends the transfer before any further pop.
        if (abort_q || i_dma_flush) begin
          state_d = StDone;
        end else if (!i_fifo_empty) begin
          fifo_read_d = 1'b1;
          state_d     = StRead;
        end
      end
      StRead: begin
        if (i_dma_flush) abort_d = 1'b1;
        state_d = StLatch;
      end
      StLatch: begin
        if (i_dma_flush) abort_d = 1'b1;
        data_d        = i_fifo_data;
        mem_request_d = 1'b1;
        state_d       = StWrite;
      end
      StWrite: begin
        // The popped word is always committed; an abort only takes effect after its ack.
        if (i_mem_ack) begin
          mem_request_d = 1'b0;
          address_d     = address_q + ADDR_W'(1);
          remaining_d   = remaining_q - LENGTH_W'(1);
          if (remaining_q == LENGTH_W'(1) || abort_q || i_dma_flush) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end else if (i_dma_flush) begin
          abort_d = 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= StIdle;
      abort_q       <= 1'b0;
      remaining_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fifo_read_q   <= 1'b0;
      mem_request_q <= 1'b0;
      bank_q        <= '0;
      address_q     <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      abort_q       <= abort_d;
      remaining_q   <= remaining_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fifo_read_q   <= fifo_read_d;
      mem_request_q <= mem_request_d;
      bank_q        <= bank_d;
      address_q     <= address_d;
      data_q        <= data_d;
    end
  end

  assign o_dma_busy    = busy_q;
  assign o_dma_done    = done_q;
  assign o_fifo_read   = fifo_read_q;
  assign o_mem_request = mem_request_q;
  assign o_mem_write   = mem_request_q;
  assign o_mem_bank    = bank_q;
  assign o_mem_address = address_q;
  assign o_mem_data    = data_q;

endmodule

// File: tb/tb_usb_dma_controller.sv
// Randomized bench for usb_dma_controller: FIFO and memory models plus a transfer-level
// reference built from bank/address/length/flush rules.
module tb_usb_dma_controller;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_dma_start = 1'b0;
  logic        i_dma_flush = 1'b0;
  logic [3:0]  i_dma_bank = 4'h0;
  logic [23:0] i_dma_address = 24'h0;
  logic [19:0] i_dma_length = 20'h0;
  logic        i_fifo_empty = 1'b1;
  logic [31:0] i_fifo_data = 32'h0;
  logic        i_mem_ack = 1'b0;
  logic        o_dma_busy, o_dma_done, o_fifo_read, o_mem_request, o_mem_write;
  logic [3:0]  o_mem_bank;
  logic [23:0] o_mem_address;
  logic [31:0] o_mem_data;

  usb_dma_controller dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_dma_start   (i_dma_start),
    .i_dma_flush   (i_dma_flush),
    .i_dma_bank    (i_dma_bank),
    .i_dma_address (i_dma_address),
    .i_dma_length  (i_dma_length),
    .o_dma_busy    (o_dma_busy),
    .o_dma_done    (o_dma_done),
    .i_fifo_empty  (i_fifo_empty),
    .o_fifo_read   (o_fifo_read),
    .i_fifo_data   (i_fifo_data),
    .o_mem_request (o_mem_request),
    .o_mem_write   (o_mem_write),
    .o_mem_bank    (o_mem_bank),
    .o_mem_address (o_mem_address),
    .o_mem_data    (o_mem_data),
    .i_mem_ack     (i_mem_ack)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int failed = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] fifo_pend = 32'h0;
  logic        fifo_pend_v = 1'b0;
  logic        fifo_hold = 1'b0;
  logic [59:0] writes[$];
  logic [59:0] snap = '0;
  logic        req_prev = 1'b0;
  int pops = 0, underflow = 0, done_cnt = 0, busy_cnt = 0, unstable = 0, req_in_hold = 0;
  int wait_cnt = 0, ack_delay = 0, cycle = 0, start_cyc = 0, done_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Negedge half of every cycle: observe outputs, play FIFO and memory-bus partner.
  task automatic monitor_step();
    cycle++;
    if (i_dma_start) start_cyc = cycle;
    if (o_dma_done) begin
      done_cnt++;
      done_cyc = cycle;
    end
    if (o_dma_busy) busy_cnt++;
    if (fifo_pend_v) begin
      i_fifo_data = fifo_pend;
      fifo_pend_v = 1'b0;
    end
    if (o_fifo_read) begin
      pops++;
      if (fifo_q.size() > 0) begin
        fifo_pend   = fifo_q.pop_front();
        fifo_pend_v = 1'b1;
      end else begin
        underflow++;
      end
    end
    i_fifo_empty = fifo_hold || (fifo_q.size() == 0);
    if (fifo_hold && o_mem_request) req_in_hold++;
    if (o_mem_write !== o_mem_request) unstable++;
    if (o_mem_request) begin
      if (!req_prev) begin
        snap     = {o_mem_bank, o_mem_address, o_mem_data};
        wait_cnt = 0;
      end else if ({o_mem_bank, o_mem_address, o_mem_data} !== snap) begin
        unstable++;
      end
      if (!i_mem_ack && wait_cnt >= ack_delay) begin
        i_mem_ack = 1'b1;
        writes.push_back({o_mem_bank, o_mem_address, o_mem_data});
      end else begin
        i_mem_ack = 1'b0;
      end
      wait_cnt++;
    end else begin
      i_mem_ack = 1'b0;
    end
    req_prev = o_mem_request;
  endtask

  task automatic tick();
    @(negedge i_clk);
    monitor_step();
    @(posedge i_clk);
    #1;
  endtask

  // flush_after > 0: flush in the cycle after that many pops; < 0: flush while stalled in fetch.
  task automatic run_xfer(input string tag, input logic [3:0] bank, input logic [23:0] addr,
                          input logic [19:0] len, input int delay, input int flush_after,
                          input int stall, input bit restart);
    logic [31:0] words[$];
    logic [59:0] expw;
    logic [63:0] got;
    logic [23:0] a;
    int n_exp, nfifo, cyc;
    bit flushed;
    words = fifo_q;
    nfifo = fifo_q.size();
    writes.delete();
    pops = 0; underflow = 0; done_cnt = 0; busy_cnt = 0; unstable = 0; req_in_hold = 0;
    ack_delay = delay;
    fifo_hold = (stall > 0);
    if (flush_after < 0) n_exp = 0;
    else if (flush_after > 0 && flush_after < int'(len)) n_exp = flush_after;
    else n_exp = int'(len);

    i_dma_start = 1'b1; i_dma_bank = bank; i_dma_address = addr; i_dma_length = len;
    tick();
    i_dma_start = 1'b0;
    cyc = 0;
    flushed = 1'b0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (stall > 0 && cyc == stall) fifo_hold = 1'b0;
      if (flush_after > 0 && !flushed && pops == flush_after) begin
        i_dma_flush = 1'b1;
        flushed = 1'b1;
      end
      if (flush_after < 0 && cyc == 3) i_dma_flush = 1'b1;
      if (restart && cyc == 6 && o_dma_busy) begin
        i_dma_start = 1'b1; i_dma_bank = ~bank; i_dma_address = addr + 24'd100;
        i_dma_length = len + 20'd3;
      end
      tick();
      i_dma_flush = 1'b0;
      i_dma_start = 1'b0;
      cyc++;
    end
    repeat (3) tick();
    fifo_hold = 1'b0;

    check({tag, " done pulse"}, 64'(done_cnt), 64'(1));
    check({tag, " write count"}, 64'(writes.size()), 64'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      a    = addr + 24'(i);
      expw = {bank, a, (i < words.size()) ? words[i] : 32'h0};
      got  = (i < writes.size()) ? {4'h0, writes[i]} : 64'hDEAD_0000_0000_0000;
      check($sformatf("%s write %0d", tag, i), got, {4'h0, expw});
    end
    check({tag, " pops"}, 64'(pops), 64'(n_exp));
    check({tag, " fifo left"}, 64'(fifo_q.size()), 64'(nfifo - n_exp));
    check({tag, " bus stable"}, 64'(unstable + underflow + req_in_hold), 64'(0));
    check({tag, " idle after"}, {62'h0, o_dma_busy, o_mem_request}, 64'(0));
  endtask

  initial begin
    logic [3:0]  bank;
    logic [23:0] addr;
    logic [19:0] len;
    int fa, st;
    int cyc;

    repeat (3) tick();
    check("reset busy/done/read", {61'h0, o_dma_busy, o_dma_done, o_fifo_read}, 64'(0));
    check("reset req/write", {62'h0, o_mem_request, o_mem_write}, 64'(0));
    check("reset bank/addr", {36'h0, o_mem_bank, o_mem_address}, 64'(0));
    check("reset data", 64'(o_mem_data), 64'(0));
    i_reset = 1'b0;
    tick();

    fifo_q.delete();
    fifo_q.push_back(32'hA); fifo_q.push_back(32'hB); fifo_q.push_back(32'hC);
    run_xfer("basic3", 4'h1, 24'hFC0000, 20'd3, 0, 0, 0, 1'b0);
    check("basic3 busy cycles", 64'(busy_cnt >= 11 && busy_cnt <= 13), 64'(1));

    fifo_q.delete();
    fifo_q.push_back($urandom);
    run_xfer("len0", 4'h7, 24'h000123, 20'd0, 0, 0, 0, 1'b0);
    check("len0 done latency", 64'(done_cyc - start_cyc), 64'(2));
    check("len0 busy cycles", 64'(busy_cnt), 64'(1));
    fifo_q.delete();

    repeat (2) fifo_q.push_back($urandom);
    run_xfer("stall", 4'h2, 24'h000400, 20'd2, 0, 0, 10, 1'b0);

    repeat (2) fifo_q.push_back($urandom);
    run_xfer("wrap", 4'h9, 24'hFFFFFF, 20'd2, 0, 0, 0, 1'b0);

    repeat (4) fifo_q.push_back($urandom);
    run_xfer("flush", 4'h3, 24'h001000, 20'd4, 0, 1, 0, 1'b0);
    fifo_q.delete();

    repeat (2) fifo_q.push_back($urandom);
    run_xfer("flush fetch", 4'h4, 24'h002000, 20'd2, 0, -1, 1000, 1'b0);
    fifo_q.delete();

    repeat (2) fifo_q.push_back($urandom);
    run_xfer("slow ack", 4'h5, 24'h00ABCD, 20'd2, 5, 0, 0, 1'b1);
    fifo_q.delete();

    // Reset while a write is waiting for its ack.
    repeat (3) fifo_q.push_back($urandom);
    ack_delay = 1000;
    done_cnt = 0;
    i_dma_start = 1'b1; i_dma_bank = 4'h5; i_dma_address = 24'h123456; i_dma_length = 20'd3;
    tick();
    i_dma_start = 1'b0;
    cyc = 0;
    while (!o_mem_request && cyc < 50) begin
      tick();
      cyc++;
    end
    check("rst req up", 64'(o_mem_request), 64'(1));
    repeat (3) tick();
    check("rst addr held", 64'(o_mem_address), 64'(24'h123456));
    i_reset = 1'b1;
    tick();
    check("rst req/busy drop", {62'h0, o_mem_request, o_dma_busy}, 64'(0));
    check("rst addr cleared", 64'(o_mem_address), 64'(0));
    i_reset = 1'b0;
    repeat (5) tick();
    check("rst no done", 64'(done_cnt), 64'(0));
    fifo_q.delete();

    for (int it = 0; it < 12; it++) begin
      bank = 4'($urandom);
      addr = ($urandom_range(0, 1) == 1) ? 24'hFFFFFF - 24'($urandom_range(0, 3))
                                          : 24'($urandom);
      len  = 20'($urandom_range(0, 6));
      fa   = (len >= 20'd2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, int'(len) - 1) : 0;
      st   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
      fifo_q.delete();
      repeat (int'(len) + $urandom_range(0, 2)) fifo_q.push_back($urandom);
      run_xfer($sformatf("rand%0d", it), bank, addr, len, $urandom_range(0, 3), fa, st,
               (len >= 20'd2) && ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/usb_dma_controller.md
Name: usb_dma_controller

Overview:
- Sequences the debug/USB DMA channel: on a start pulse it moves a programmed number of 32-bit words from the USB receive FIFO into cartridge memory (SDRAM bank + word address) over the shared memory bus.
- Sits between the cart control register block (start/bank/address/length/flush) and the memory bus arbiter.
- Reports busy status back to the USB status register.

Parameters:
- LENGTH_W, 20, width of word-count register.
- ADDR_W, 24, width of word address (wraps at 2^ADDR_W).

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_dma_start  input  1  one-cycle start pulse
- i_dma_flush  input  1  one-cycle abort pulse
- i_dma_bank  input  4  target memory bank
- i_dma_address  input  ADDR_W  start word address
- i_dma_length  input  LENGTH_W  number of words to transfer
- o_dma_busy  output  1  transfer in progress
- o_dma_done  output  1  one-cycle pulse at completion or abort
- i_fifo_empty  input  1  USB RX FIFO empty
- o_fifo_read  output  1  FIFO pop strobe, one cycle per word
- i_fifo_data  input  32  FIFO data, valid the cycle after o_fifo_read is high
- o_mem_request  output  1  memory write request
- o_mem_write  output  1  always 1 while o_mem_request is high
- o_mem_bank  output  4  bank of current write
- o_mem_address  output  ADDR_W  word address of current write
- o_mem_data  output  32  write data
- i_mem_ack  input  1  write accepted; only valid while o_mem_request is high

Behaviour:
- Clock and reset: reset i_reset, synchronous, active-high; clock i_clk.
- Reset values: all outputs 0; o_mem_address 0; o_mem_bank 0; o_mem_data 0; FSM in IDLE; remaining count 0; abort flag 0.
- All outputs are registered.
- States: IDLE, FETCH, READ, LATCH, WRITE, DONE.
- IDLE:
  - On i_dma_start, latch bank, address and length; o_dma_busy goes to 1 next cycle.
  - If length == 0, go to DONE; otherwise go to FETCH.
- FETCH: if abort flag is set, go to DONE. Else if !i_fifo_empty, assert o_fifo_read for the next cycle and go to READ. Else stay in FETCH (stall indefinitely).
- READ: o_fifo_read is high in this cycle only; go to LATCH.
- LATCH: capture i_fifo_data into o_mem_data; assert o_mem_request and o_mem_write; go to WRITE.
- WRITE:
  - Hold request, bank, address and data stable until i_mem_ack is sampled high.
  - On ack: drop o_mem_request next cycle, increment address modulo 2^ADDR_W, decrement remaining count.
  - If the count reaches 0 or the abort flag is set, go to DONE; else go to FETCH.
- DONE: pulse o_dma_done for one cycle; clear o_dma_busy in the same cycle; clear abort flag; return to IDLE.
- Minimum throughput: 4 cycles per word with a non-empty FIFO and ack one cycle after request.
- i_dma_start while busy: ignored; latched parameters are unchanged.
- i_dma_flush:
  - In IDLE: no effect.
  - In FETCH: abort takes effect next evaluation; no FIFO pop occurs.
  - In READ/LATCH: the popped word is still written; abort happens after its ack. A bus transaction is never abandoned mid-request.
- Flush and start in the same cycle in IDLE: start wins; flush is ignored.
- The bank is fixed for the transfer; address wrap does not change the bank.
- i_reset mid-transfer: immediate return to IDLE; o_mem_request drops next cycle; no o_dma_done pulse.

Test Plan:
- Length 3, bank 1, address 0xFC0000, FIFO preloaded 0xA, 0xB, 0xC, ack 1 cycle after request -> writes (1, 0xFC0000, 0xA), (1, 0xFC0001, 0xB), (1, 0xFC0002, 0xC); exactly 3 pops; one o_dma_done; busy high for 12±1 cycles.
- Length 0 -> no o_fifo_read and no o_mem_request; o_dma_done 2 cycles after start; busy high 1 cycle.
- Length 2, FIFO empty for 10 cycles then filled -> FSM stalls in FETCH; no request during the stall; both words written afterwards.
- Address 0xFFFFFF, length 2 -> second write to address 0x000000, bank unchanged.
- Flush pulsed in the cycle after the first o_fifo_read, length 4 -> first word written and acked; no further pops; o_dma_done after that ack; remaining FIFO words untouched.
- Ack delayed 5 cycles -> request, address and data stable throughout; a second start during the transfer is ignored; i_reset asserted mid-WRITE -> request drops, busy 0, no done pulse.
